// File: rtl/mercury_ps2_pkg.sv
// mercury_ps2_pkg
// Shared definitions for the Mercury PS/2 keyboard receiver:
//   - frame FSM state encoding
//   - scan-code prefix bytes (extended / break)
//   - default filter depth and mid-frame stall limit
//   - odd-parity helper used when accepting a frame
package mercury_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int PS2_FILTER_LEN_DEF  = 8;
  localparam int PS2_TIMEOUT_CYC_DEF = 50000;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/mercury_ps2_filter.sv
// mercury_ps2_filter
// Brings the raw PS/2 pins into app_clk space and de-glitches the clock line.
// Ports:
//   app_clk   in  : sole clock
//   app_rst   in  : synchronous active-high reset
//   ps2_clk   in  : raw PS/2 clock pin (asynchronous)
//   ps2_data  in  : raw PS/2 data pin (asynchronous)
//   clk_f     out : filtered PS/2 clock, changes only after FILTER_LEN agreeing samples
//   fall      out : one-cycle strobe in the cycle clk_f goes 1->0
//   data_s    out : synchronized PS/2 data
module mercury_ps2_filter
  import mercury_ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic app_clk,
  input  logic app_rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_f,
  output logic fall,
  output logic data_s
);

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] window;

  // The current synchronized sample counts as the newest history entry, so a
  // pin edge reaches clk_f after exactly 2 + FILTER_LEN cycles.
  assign window = {hist, clk_sync[1]};
  assign data_s = data_sync[1];

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      hist      <= '1;
      clk_f     <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      hist      <= window[FILTER_LEN-2:0];
      fall      <= 1'b0;
      if (window == '1) begin
        clk_f <= 1'b1;
      end else if (window == '0) begin
        clk_f <= 1'b0;
        fall  <= clk_f;
      end
    end
  end

endmodule

// File: rtl/mercury_ps2_rx.sv
// mercury_ps2_rx
// PS/2 keyboard receiver: deserializes 11-bit device-to-host frames and folds
// the E0 (extended) and F0 (break) prefixes into single key events.
// Ports:
//   app_clk     in     : sole clock (50 MHz)
//   app_rst     in     : synchronous active-high reset
//   ps2_clk     in     : raw PS/2 clock pin
//   ps2_data    in     : raw PS/2 data pin
//   byte_valid  out    : pulse, good raw byte received
//   byte_data   out[8] : last good raw byte (held)
//   key_valid   out    : pulse, complete key event
//   key_code    out[8] : scan code of last key event (held)
//   key_ext     out    : last key event was E0-prefixed (held)
//   key_rel     out    : last key event was a release (held)
//   frame_err   out    : pulse, parity or stop-bit failure
//   timeout_err out    : pulse, frame stalled mid-way
//   busy        out    : frame in progress
//
// state  | meaning
// IDLE   | waiting for a start bit (falling clk_f with data 0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit, then accept or reject the frame
module mercury_ps2_rx
  import mercury_ps2_pkg::*;
#(
  parameter int FILTER_LEN  = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
  input  logic       app_clk,
  input  logic       app_rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_rel,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The error is registered, so fire one count early: timeout_err then shows
  // up in the cycle the count would have reached TIMEOUT_CYC-1.
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT_CYC - 2);

  logic clk_f, fall, data_s;
  logic clk_f_q;
  logic clk_edge;

  ps2_state_e state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       par_bit, par_bit_nxt;
  logic       accept, reject, wd_fire;

  logic [WD_W-1:0] wd_cnt;
  logic            ext_pend, rel_pend;

  mercury_ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .app_clk  (app_clk),
    .app_rst  (app_rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_f    (clk_f),
    .fall     (fall),
    .data_s   (data_s)
  );

  assign clk_edge = clk_f ^ clk_f_q;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_bit_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    accept      = 1'b0;
    reject      = 1'b0;
    wd_fire     = 1'b0;
    // A clk_f edge restarts the watchdog, so it takes precedence over a stall.
    if (state != ST_IDLE && !clk_edge && wd_cnt == WD_FIRE) begin
      wd_fire   = 1'b1;
      state_nxt = ST_IDLE;
    end else if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!data_s) begin
            shreg_nxt   = 8'd0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = ST_DATA;
          end
        end
        ST_DATA: begin
          shreg_nxt   = {data_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          par_bit_nxt = data_s;
          state_nxt   = ST_STOP;
        end
        ST_STOP: begin
          if (data_s && odd_parity_ok(shreg, par_bit)) accept = 1'b1;
          else                                         reject = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      clk_f_q     <= 1'b1;
      wd_cnt      <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'd0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= 8'd0;
      key_ext     <= 1'b0;
      key_rel     <= 1'b0;
      ext_pend    <= 1'b0;
      rel_pend    <= 1'b0;
    end else begin
      clk_f_q <= clk_f;

      if (state == ST_IDLE || clk_edge) wd_cnt <= '0;
      else                              wd_cnt <= wd_cnt + 1'b1;

      byte_valid  <= accept;
      frame_err   <= reject;
      timeout_err <= wd_fire;
      if (accept) byte_data <= shreg;

      key_valid <= 1'b0;
      if (frame_err || timeout_err) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_data == PS2_BRK) begin
          rel_pend <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_code  <= byte_data;
          key_ext   <= ext_pend;
          key_rel   <= rel_pend;
          ext_pend  <= 1'b0;
          rel_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mercury_ps2_rx.sv
// Testbench for mercury_ps2_rx: drives PS/2 frames onto the pins and compares
// the received bytes and key events with a byte-level reference model.
module tb_mercury_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 600;
  localparam int HALF = 20;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_t;

  logic       app_clk  = 1'b0;
  logic       app_rst  = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       byte_valid, key_valid, key_ext, key_rel, frame_err, timeout_err, busy;
  logic [7:0] byte_data, key_code;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mercury_ps2_rx #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .app_clk     (app_clk),
    .app_rst     (app_rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_rel     (key_rel),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #10 app_clk = ~app_clk;
  always @(posedge app_clk) cyc = cyc + 1;

  // ---------------- monitor ----------------
  logic [7:0] got_bytes[$];
  key_t       got_keys[$];
  int         bv_lat[$];
  int         kv_lat[$];
  int         busy_lat[$];
  int         n_ferr = 0, n_terr = 0, terr_lat = -1, busy_bad = 0;
  int         last_bv_cyc = 0, start_fall_cyc = 0, stop_fall_cyc = 0, last_rise_cyc = 0;
  logic       busy_q = 1'b0;

  always @(posedge app_clk) begin
    key_t k;
    #1;
    if (byte_valid) begin
      got_bytes.push_back(byte_data);
      bv_lat.push_back(cyc - stop_fall_cyc);
      last_bv_cyc = cyc;
    end
    if (key_valid) begin
      k = '{code: key_code, ext: key_ext, rel: key_rel};
      got_keys.push_back(k);
      kv_lat.push_back(cyc - last_bv_cyc);
    end
    if (frame_err) n_ferr++;
    if (timeout_err) begin
      n_terr++;
      terr_lat = cyc - last_rise_cyc;
    end
    if ((byte_valid || frame_err || timeout_err) && busy) busy_bad++;
    if (busy && !busy_q) busy_lat.push_back(cyc - start_fall_cyc);
    busy_q = busy;
  end

  // ---------------- reference model (byte level) ----------------
  logic [7:0] exp_bytes[$];
  key_t       exp_keys[$];
  logic [7:0] exp_byte = 8'h00;
  key_t       exp_key  = '0;
  logic       ext_p = 1'b0, rel_p = 1'b0;
  int         exp_ferr = 0, exp_terr = 0;

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_ferr++;
      ext_p = 1'b0;
      rel_p = 1'b0;
    end else begin
      exp_bytes.push_back(b);
      exp_byte = b;
      if (b == 8'hE0)      ext_p = 1'b1;
      else if (b == 8'hF0) rel_p = 1'b1;
      else begin
        exp_key = '{code: b, ext: ext_p, rel: rel_p};
        exp_keys.push_back(exp_key);
        ext_p = 1'b0;
        rel_p = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_nbytes"},   32'(got_bytes.size()), 32'(exp_bytes.size()));
    chk({tag, "_nkeys"},    32'(got_keys.size()),  32'(exp_keys.size()));
    chk({tag, "_nferr"},    32'(n_ferr),           32'(exp_ferr));
    chk({tag, "_nterr"},    32'(n_terr),           32'(exp_terr));
    chk({tag, "_byte_data"}, 32'(byte_data),       32'(exp_byte));
    chk({tag, "_key_code"}, 32'(key_code),         32'(exp_key.code));
    chk({tag, "_key_ext"},  32'(key_ext),          32'(exp_key.ext));
    chk({tag, "_key_rel"},  32'(key_rel),          32'(exp_key.rel));
    chk({tag, "_busy"},     32'(busy),             32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_outs"},
        32'({byte_valid, byte_data, key_valid, key_code, key_ext, key_rel,
             frame_err, timeout_err, busy}), 32'd0);
  endtask

  // ---------------- PS/2 device model ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge app_clk);
  endtask

  // Sends n_bits of a frame (11 = full frame). Data changes mid-high.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int glitch_bit, input int n_bits);
    logic bits [11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    bits[9]  = (($countones(b) % 2) == 0) ^ bad_par;
    bits[10] = 1'b1;
    for (int i = 0; i < n_bits; i++) begin
      wait_cyc(HALF/2);
      ps2_data = bits[i];
      if (i - 1 == glitch_bit) begin
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF/2 - 7);
      end else begin
        wait_cyc(HALF/2);
      end
      ps2_clk = 1'b0;
      if (i == 0)  start_fall_cyc = cyc;
      if (i == 10) stop_fall_cyc  = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      last_rise_cyc = cyc;
    end
    if (n_bits == 11) begin
      wait_cyc(HALF);
      ps2_data = 1'b1;
      wait_cyc(5);
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input int glitch_bit,
                       input string tag);
    send_frame(b, bad_par, glitch_bit, 11);
    model_frame(b, !bad_par);
    check_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb;
    int         sel;
    bit         bad;

    app_rst = 1'b1;
    wait_cyc(5);
    check_zero("reset");
    app_rst = 1'b0;
    wait_cyc(30);
    check_all("post_reset");

    frame(8'h1C, 1'b0, -1, "t1_make");
    frame(8'hF0, 1'b0, -1, "t2_brk");
    frame(8'h1C, 1'b0, -1, "t2_rel");
    frame(8'hE0, 1'b0, -1, "t3_ext");
    frame(8'hF0, 1'b0, -1, "t3_brk");
    frame(8'h75, 1'b0, -1, "t3_extrel");
    frame(8'h75, 1'b0, -1, "t3_plain");
    frame(8'h1C, 1'b1, -1, "t4_badpar");
    frame(8'h29, 1'b0, -1, "t4_recover");
    frame(8'h5A, 1'b0,  4, "t5_glitch");
    frame(8'hE1, 1'b0, -1, "e1_plain");

    // Stall after four data bits while an extended prefix is pending.
    frame(8'hE0, 1'b0, -1, "t6_ext");
    send_frame(8'h33, 1'b0, -1, 5);
    ps2_data = 1'b1;
    wait_cyc(FL + TO + 40);
    exp_terr++;
    ext_p = 1'b0;
    rel_p = 1'b0;
    chk("t6_timeout_latency", 32'(terr_lat), 32'(FL + 2 + TO));
    check_all("t6_timeout");
    frame(8'h1C, 1'b0, -1, "t6_after");

    // Same stall, but reset is applied mid-frame instead.
    frame(8'hE0, 1'b0, -1, "t6r_ext");
    send_frame(8'h33, 1'b0, -1, 5);
    ps2_data = 1'b1;
    wait_cyc(5);
    app_rst = 1'b1;
    wait_cyc(3);
    check_zero("t6r_in_reset");
    app_rst = 1'b0;
    ext_p    = 1'b0;
    rel_p    = 1'b0;
    exp_byte = 8'h00;
    exp_key  = '0;
    wait_cyc(TO + 60);
    check_all("t6r_after_reset");
    frame(8'h1C, 1'b0, -1, "t6r_recover");

    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2)      rb = 8'hE0;
      else if (sel < 4) rb = 8'hF0;
      else              rb = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      frame(rb, bad, -1, "rand");
    end

    chk("busy_at_pulse", 32'(busy_bad), 32'd0);
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
      chk("byte_seq", 32'(got_bytes[i]), 32'(exp_bytes[i]));
    for (int i = 0; i < got_keys.size() && i < exp_keys.size(); i++)
      chk("key_seq", 32'(got_keys[i]), 32'(exp_keys[i]));
    foreach (bv_lat[i])   chk("byte_valid_latency", 32'(bv_lat[i]),   32'(FL + 3));
    foreach (kv_lat[i])   chk("key_valid_latency",  32'(kv_lat[i]),   32'd1);
    foreach (busy_lat[i]) chk("busy_rise_latency",  32'(busy_lat[i]), 32'(FL + 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

endmodule
